// File: rtl/prod_accum_4b.sv
// Accumulates N_TERMS unsigned 8-bit products from the array multiplier into a
// saturating ACC_W-bit result, with valid/ready handshakes on both sides.
module prod_accum_4b #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [7:0]       P,
  input  logic             P_VALID,
  output logic             P_READY,
  output logic [ACC_W-1:0] ACC,
  output logic             ACC_VALID,
  input  logic             ACC_READY,
  output logic             OVF,
  output logic             BUSY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             xfer;

  // The extra top bit of the sum is the carry out of ACC_W bits.
  function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign sum  = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, P};
  assign xfer = (state_q == S_ACCUM) && P_VALID;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          acc_d = sat(sum);
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | sum[ACC_W];
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (ACC_READY) begin
          if (START) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign P_READY   = (state_q == S_ACCUM);
  assign BUSY      = (state_q == S_ACCUM);
  assign ACC_VALID = (state_q == S_DONE);
  assign ACC       = acc_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_prod_accum_4b.sv
// Directed bench for prod_accum_4b: default build, a narrow 9-bit build for
// saturation, and a single-term build, all sharing clock and reset.
module tb_prod_accum_4b;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Instance A: N_TERMS=4, ACC_W=12
  logic        start_a = 0, pv_a = 0, ar_a = 0;
  logic [7:0]  p_a = 0;
  logic        prdy_a, av_a, ovf_a, busy_a;
  logic [11:0] acc_a;

  // Instance B: N_TERMS=4, ACC_W=9
  logic        start_b = 0, pv_b = 0, ar_b = 0;
  logic [7:0]  p_b = 0;
  logic        prdy_b, av_b, ovf_b, busy_b;
  logic [8:0]  acc_b;

  // Instance C: N_TERMS=1, ACC_W=12
  logic        start_c = 0, pv_c = 0, ar_c = 0;
  logic [7:0]  p_c = 0;
  logic        prdy_c, av_c, ovf_c, busy_c;
  logic [11:0] acc_c;

  prod_accum_4b #(.N_TERMS(4), .ACC_W(12)) u_a (
    .CLK(CLK), .RST(RST), .START(start_a), .P(p_a), .P_VALID(pv_a),
    .P_READY(prdy_a), .ACC(acc_a), .ACC_VALID(av_a), .ACC_READY(ar_a),
    .OVF(ovf_a), .BUSY(busy_a));

  prod_accum_4b #(.N_TERMS(4), .ACC_W(9)) u_b (
    .CLK(CLK), .RST(RST), .START(start_b), .P(p_b), .P_VALID(pv_b),
    .P_READY(prdy_b), .ACC(acc_b), .ACC_VALID(av_b), .ACC_READY(ar_b),
    .OVF(ovf_b), .BUSY(busy_b));

  prod_accum_4b #(.N_TERMS(1), .ACC_W(12)) u_c (
    .CLK(CLK), .RST(RST), .START(start_c), .P(p_c), .P_VALID(pv_c),
    .P_READY(prdy_c), .ACC(acc_c), .ACC_VALID(av_c), .ACC_READY(ar_c),
    .OVF(ovf_c), .BUSY(busy_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int ready_cnt;
  int valid_idx;
  int run_sum;
  int exp_b;
  logic [7:0] gap_p [4];
  logic [7:0] seq_p [4];

  initial begin
    gap_p[0] = 8'd3; gap_p[1] = 8'd0; gap_p[2] = 8'd7; gap_p[3] = 8'd2;
    seq_p[0] = 8'd1; seq_p[1] = 8'd2; seq_p[2] = 8'd3; seq_p[3] = 8'd4;

    // Reset state
    #1;
    check("rst_acc",   {20'd0, acc_a}, 0);
    check("rst_prdy",  {31'd0, prdy_a}, 0);
    check("rst_valid", {31'd0, av_a}, 0);
    check("rst_busy",  {31'd0, busy_a}, 0);
    check("rst_ovf",   {31'd0, ovf_a}, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 15x15 four times, P_VALID held high, downstream not ready
    start_a = 1;
    @(negedge CLK);
    start_a = 0; p_a = 8'd225; pv_a = 1;
    ready_cnt = 0; valid_idx = -1;
    for (int i = 0; i < 8; i++) begin
      ready_cnt += int'(prdy_a);
      if (av_a && valid_idx < 0) valid_idx = i;
      @(negedge CLK);
    end
    check("mac_prdy_cycles", ready_cnt, 4);
    check("mac_latency", valid_idx, 4);
    check("mac_acc", {20'd0, acc_a}, 900);
    check("mac_ovf", {31'd0, ovf_a}, 0);
    pv_a = 0;

    // DONE holds while ACC_READY low
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_acc",   {20'd0, acc_a}, 900);
      check("hold_valid", {31'd0, av_a}, 1);
    end
    ar_a = 1; start_a = 1;
    @(negedge CLK);
    check("b2b_busy",  {31'd0, busy_a}, 1);
    check("b2b_acc",   {20'd0, acc_a}, 0);
    check("b2b_ovf",   {31'd0, ovf_a}, 0);
    check("b2b_valid", {31'd0, av_a}, 0);
    ar_a = 0; start_a = 0;

    // Products with a one-cycle P_VALID gap between each
    run_sum = 0;
    for (int i = 0; i < 4; i++) begin
      p_a = gap_p[i]; pv_a = 1;
      @(negedge CLK);
      run_sum += int'(gap_p[i]);
      pv_a = 0; p_a = 8'hFF;
      check("gap_acc_xfer", {20'd0, acc_a}, run_sum);
      @(negedge CLK);
      check("gap_acc_idle", {20'd0, acc_a}, run_sum);
      if (i < 3) check("gap_busy", {31'd0, busy_a}, 1);
    end
    check("gap_final", {20'd0, acc_a}, 12);
    check("gap_valid", {31'd0, av_a}, 1);
    ar_a = 1;
    @(negedge CLK);
    ar_a = 0;
    check("idle_valid", {31'd0, av_a}, 0);
    check("idle_busy",  {31'd0, busy_a}, 0);

    // Saturation on the 9-bit build
    start_b = 1;
    @(negedge CLK);
    start_b = 0; p_b = 8'd225; pv_b = 1;
    exp_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      exp_b = (exp_b + 225 > 511) ? 511 : exp_b + 225;
      check("sat_acc", {23'd0, acc_b}, exp_b);
      check("sat_ovf", {31'd0, ovf_b}, (i >= 2) ? 1 : 0);
    end
    pv_b = 0;
    check("sat_valid", {31'd0, av_b}, 1);
    ar_b = 1; start_b = 1;
    @(negedge CLK);
    ar_b = 0; start_b = 0;
    check("sat_restart_ovf", {31'd0, ovf_b}, 0);
    check("sat_restart_acc", {23'd0, acc_b}, 0);

    // Single-term build with a zero product
    start_c = 1;
    @(negedge CLK);
    start_c = 0; p_c = 8'd0; pv_c = 1;
    @(negedge CLK);
    pv_c = 0;
    check("one_valid", {31'd0, av_c}, 1);
    check("one_acc",   {20'd0, acc_c}, 0);
    start_c = 1;
    @(negedge CLK);
    start_c = 0;
    check("one_start_ignored_valid", {31'd0, av_c}, 1);
    check("one_start_ignored_busy",  {31'd0, busy_c}, 0);
    ar_c = 1;
    @(negedge CLK);
    ar_c = 0;
    check("one_release", {31'd0, av_c}, 0);

    // Asynchronous reset mid-accumulation
    start_a = 1;
    @(negedge CLK);
    start_a = 0; p_a = 8'd5; pv_a = 1;
    @(negedge CLK);
    p_a = 8'd6;
    @(negedge CLK);
    pv_a = 0;
    check("abort_partial", {20'd0, acc_a}, 11);
    #2 RST = 1'b1;
    #1;
    check("abort_acc",  {20'd0, acc_a}, 0);
    check("abort_prdy", {31'd0, prdy_a}, 0);
    check("abort_busy", {31'd0, busy_a}, 0);
    check("abort_ovf",  {31'd0, ovf_a}, 0);
    check("abort_valid",{31'd0, av_a}, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_valid", {31'd0, av_a}, 0);
    start_a = 1;
    @(negedge CLK);
    start_a = 0; pv_a = 1;
    for (int i = 0; i < 4; i++) begin
      p_a = seq_p[i];
      @(negedge CLK);
    end
    pv_a = 0;
    check("post_rst_acc",   {20'd0, acc_a}, 10);
    check("post_rst_done",  {31'd0, av_a}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
